// File: rtl/cgra_ctrl_pkg.sv
// Shared definitions for the CGRA configuration sequencer and the accelerator register map.
package cgra_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StPollWait,
        StRdReq,
        StRdResp,
        StFinish
    } seq_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY      = 2'b00;

    // Register map of the accelerator window as seen through the crossbar.
    localparam logic [63:0] CGRA_BASE_ADDR     = 64'h5000_0000;
    localparam logic [15:0] CGRA_START_OFFSET  = 16'h0070;
    localparam logic [15:0] CGRA_STATUS_OFFSET = 16'h0078;

endpackage

// File: rtl/cgra_cfg_sequencer_if.sv
// Single-beat AXI4 subset used by the configuration sequencer (master) and its slave.
interface cgra_cfg_sequencer_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64
);
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic                        w_valid;
    logic                        w_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        b_valid;
    logic                        b_ready;
    logic [1:0]                  b_resp;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic                        r_valid;
    logic                        r_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

endinterface

// File: rtl/cgra_cfg_sequencer.sv
// Writes a configuration table to the CGRA register window, kicks the start register,
// then polls the status register until done or until the poll budget is exhausted.
module cgra_cfg_sequencer
    import cgra_ctrl_pkg::*;
#(
    parameter int unsigned               AXI_ADDR_WIDTH = 64,
    parameter int unsigned               AXI_DATA_WIDTH = 64,
    parameter int unsigned               NUM_CFG        = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(CGRA_BASE_ADDR),
    parameter logic [15:0]               START_OFFSET   = CGRA_START_OFFSET,
    parameter logic [15:0]               STATUS_OFFSET  = CGRA_STATUS_OFFSET,
    parameter int unsigned               DONE_BIT       = 0,
    parameter int unsigned               POLL_GAP       = 8,
    parameter int unsigned               MAX_POLLS      = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [$clog2(NUM_CFG+1)-1:0]       cfg_count_i,
    input  logic [NUM_CFG*16-1:0]              cfg_offset_i,
    input  logic [NUM_CFG*64-1:0]              cfg_data_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               error_o,
    cgra_cfg_sequencer_if.master               axi
);

    localparam int unsigned IdxW  = $clog2(NUM_CFG + 1);
    localparam int unsigned PollW = $clog2(MAX_POLLS + 1);
    localparam int unsigned GapW  = $clog2(POLL_GAP + 1);
    localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

    localparam logic [PollW-1:0] PollLimit = PollW'(MAX_POLLS);
    localparam logic [GapW-1:0]  GapLast   = GapW'(POLL_GAP - 1);

    // Offset of the write selected by (idx, is_start); the start register overrides the table.
    function automatic logic [15:0] pick_off(input logic [IdxW-1:0]       idx,
                                             input logic                  use_start,
                                             input logic [NUM_CFG*16-1:0] offs);
        logic [15:0] o;
        o = START_OFFSET;
        if (!use_start) begin
            o = '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (idx == IdxW'(i)) o = offs[16*i +: 16];
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] pick_data(input logic [IdxW-1:0]       idx,
                                              input logic                  use_start,
                                              input logic [NUM_CFG*64-1:0] data);
        logic [63:0] d;
        d = 64'd1;
        if (!use_start) begin
            d = '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (idx == IdxW'(i)) d = data[64*i +: 64];
            end
        end
        return d;
    endfunction

    seq_state_e                state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      is_start_q, is_start_d;
    logic [PollW-1:0]          poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0]           gap_cnt_q, gap_cnt_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]          w_strb_q, w_strb_d;
    logic                      b_ready_q, b_ready_d;
    logic                      ar_valid_q, ar_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                      r_ready_q, r_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    // Only the done bit of the status word is meaningful here.
    logic unused_rdata;
    assign unused_rdata = ^axi.r_data;

    // Next-state and registered-output logic.
    always_comb begin
        logic             aw_hs, w_hs, b_hs, r_hs, ld_wr, ld_start;
        logic [IdxW-1:0]  ld_idx, idx_inc;
        logic [PollW-1:0] poll_inc;

        state_d    = state_q;
        idx_d      = idx_q;
        is_start_d = is_start_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        r_ready_d  = r_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;

        aw_hs    = aw_valid_q & axi.aw_ready;
        w_hs     = w_valid_q & axi.w_ready;
        b_hs     = axi.b_valid & b_ready_q;
        r_hs     = axi.r_valid & r_ready_q;
        idx_inc  = idx_q + IdxW'(1);
        poll_inc = poll_cnt_q + PollW'(1);
        ld_wr    = 1'b0;
        ld_idx   = '0;
        ld_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    error_d    = 1'b0;
                    idx_d      = '0;
                    is_start_d = (cfg_count_i == '0);
                    busy_d     = 1'b1;
                    ld_wr      = 1'b1;
                    ld_idx     = '0;
                    ld_start   = (cfg_count_i == '0);
                    state_d    = StWrReq;
                end
            end
            StWrReq: begin
                // AW and W complete independently; each valid drops after its own handshake.
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = StWrResp;
            end
            StWrResp: begin
                if (b_hs) begin
                    if (axi.b_resp != AXI_RESP_OKAY) begin
                        b_ready_d = 1'b0;
                        error_d   = 1'b1;
                        done_d    = 1'b1;
                        state_d   = StFinish;
                    end else if (!is_start_q) begin
                        idx_d      = idx_inc;
                        is_start_d = (idx_inc == cfg_count_i);
                        ld_wr      = 1'b1;
                        ld_idx     = idx_inc;
                        ld_start   = (idx_inc == cfg_count_i);
                        state_d    = StWrReq;
                    end else begin
                        b_ready_d  = 1'b0;
                        poll_cnt_d = '0;
                        gap_cnt_d  = '0;
                        state_d    = StPollWait;
                    end
                end
            end
            StPollWait: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d  = '0;
                    ar_valid_d = 1'b1;
                    ar_addr_d  = BASE_ADDR + AXI_ADDR_WIDTH'(STATUS_OFFSET);
                    r_ready_d  = 1'b1;
                    state_d    = StRdReq;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            StRdReq: begin
                if (ar_valid_q && axi.ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = StRdResp;
                end
            end
            StRdResp: begin
                if (r_hs) begin
                    r_ready_d = 1'b0;
                    if (axi.r_resp != AXI_RESP_OKAY) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else if (axi.r_data[DONE_BIT]) begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc == PollLimit) begin
                            error_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = StFinish;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = StPollWait;
                        end
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Launch a fresh AW/W pair for the selected table entry or the start register.
        if (ld_wr) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            aw_addr_d  = BASE_ADDR +
                         AXI_ADDR_WIDTH'(pick_off(ld_idx, ld_start, cfg_offset_i));
            w_data_d   = AXI_DATA_WIDTH'(pick_data(ld_idx, ld_start, cfg_data_i));
            w_strb_d   = '1;
            b_ready_d  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            is_start_q <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_start_q <= is_start_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            r_ready_q  <= r_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign axi.aw_valid = aw_valid_q;
    assign axi.aw_addr  = aw_addr_q;
    assign axi.w_valid  = w_valid_q;
    assign axi.w_data   = w_data_q;
    assign axi.w_strb   = w_strb_q;
    assign axi.b_ready  = b_ready_q;
    assign axi.ar_valid = ar_valid_q;
    assign axi.ar_addr  = ar_addr_q;
    assign axi.r_ready  = r_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: doc/cgra_cfg_sequencer.md
Name: cgra_cfg_sequencer

Overview:
AXI4 master-side controller that configures and launches the CGRA accelerator through the crossbar, replacing hand-timed bench stimulus.
On start_i it writes a table of (offset, data) configuration words to the accelerator register window, then writes the start register, then polls the status register until the done bit is set or a poll limit is reached.
It occupies one crossbar slave port (master role); all transfers are single-beat, 64-bit.

Parameters:
AXI_ADDR_WIDTH, 64, address width
AXI_DATA_WIDTH, 64, data width; strobe width is AXI_DATA_WIDTH/8
NUM_CFG, 8, max configuration entries per run
BASE_ADDR, 64'h5000_0000, accelerator register window base
START_OFFSET, 16'h0070, start register offset; written with data 1
STATUS_OFFSET, 16'h0078, status register offset
DONE_BIT, 0, bit of status word signalling completion
POLL_GAP, 8, idle cycles between polls (>=1)
MAX_POLLS, 1024, polls before timeout error

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled in IDLE only
cfg_count_i  in  $clog2(NUM_CFG+1)  entries to write (0..NUM_CFG)
cfg_offset_i  in  NUM_CFG*16  entry i offset at [16i+:16]
cfg_data_i  in  NUM_CFG*64  entry i data at [64i+:64]
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse at run end (success or error)
error_o  out  1  sticky error flag, cleared on accepted start
aw_valid_o / aw_ready_i / aw_addr_o  out/in/out  1/1/AXI_ADDR_WIDTH  write address channel
w_valid_o / w_ready_i  out/in  1/1  write data handshake
w_data_o / w_strb_o  out/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8  write data and strobe
b_valid_i / b_ready_o / b_resp_i  in/out/in  1/1/2  write response channel
ar_valid_o / ar_ready_i / ar_addr_o  out/in/out  1/1/AXI_ADDR_WIDTH  read address channel
r_valid_i / r_ready_o  in/out  1/1  read data handshake
r_data_i / r_resp_i  in/in  AXI_DATA_WIDTH/2  read data and response
- The integrating wrapper ties the remaining AXI fields: id 0, len 0, size 3, burst INCR, w_last 1, user 0, r_last ignored.

Behaviour:
- All outputs registered. Reset values: all valid/ready outputs 0, addr/data/strb 0, busy_o 0, done_o 0, error_o 0, FSM in IDLE, counters 0.
- States: IDLE, WR_REQ, WR_RESP, POLL_WAIT, RD_REQ, RD_RESP, FINISH.
- IDLE: on start_i, clear error_o, idx=0, is_start=0. If cfg_count_i==0, set is_start=1. Go to WR_REQ next cycle.
- start_i in any other state is ignored (no queueing).
- WR_REQ: drive aw_addr=BASE_ADDR+offset and w_data, strb all ones. The pair is (cfg_offset[idx], cfg_data[idx]), or (START_OFFSET, 1) when is_start.
- WR_REQ: aw_valid and w_valid rise in the same cycle. Each drops the cycle after its own handshake (valid&&ready); neither waits for the other.
- WR_REQ: valids stay stable and addr/data stay constant until the respective handshake. Leave when both handshakes have completed (same or different cycles). b_ready_o=1 from entering WR_REQ.
- WR_RESP: b_ready_o=1 while waiting; on b_valid_i, b_ready_o drops next cycle.
- WR_RESP, b_resp_i!=OKAY: set error_o and go to FINISH.
- WR_RESP, OKAY and !is_start: idx++. If idx==cfg_count_i, set is_start. Return to WR_REQ.
- WR_RESP, OKAY and is_start: clear poll counter, go to POLL_WAIT.
- POLL_WAIT: count POLL_GAP cycles, then RD_REQ.
- RD_REQ: ar_valid=1 with ar_addr=BASE_ADDR+STATUS_OFFSET, held until ar_ready. r_ready_o=1 from entering RD_REQ.
- RD_RESP: on r_valid_i, if r_resp_i!=OKAY, set error_o and go to FINISH.
- RD_RESP: if r_data_i[DONE_BIT]==1, go to FINISH.
- RD_RESP: otherwise poll_cnt++. If poll_cnt==MAX_POLLS, set error_o and go to FINISH; else go to POLL_WAIT.
- FINISH: done_o=1 for exactly one cycle, then IDLE. busy_o is still 1 in FINISH.
- Address arithmetic: offsets zero-extend to AXI_ADDR_WIDTH; sum is modulo 2^AXI_ADDR_WIDTH.
- idx, poll and gap counters are sized so they never wrap within the legal range.
- Reset mid-run: immediate return to reset values, including dropping valids. Legal because the crossbar and accelerator share rst_ni.

Decomposition:
- Shared package cgra_ctrl_pkg holds: the state enum, AXI_RESP_OKAY=2'b00, and default BASE/START/STATUS offsets shared with axi_cgra_top's register map.
- No sub-module is required.
- Optional sub-module cgra_axi_single_wr: the independent AW/W valid tracking, reusable by other crossbar masters.

Test Plan:
- cfg_count=2, entries (0x50,1),(0x58,3), always-ready slave, status done on 3rd poll → AW addresses 0x5000_0050, 0x5000_0058, 0x5000_0070 (data 1); 3 reads of 0x5000_0078; one done_o pulse; error_o=0.
- Back-pressure: w_ready immediate, aw_ready delayed 3 cycles → w_valid drops after 1 cycle; aw_valid held 4 cycles with stable addr; no second write issued before b handshake.
- b_resp=SLVERR on 1st config write → no further AW/AR; done_o pulse; error_o=1 until next start.
- cfg_count=0 → first and only write targets 0x5000_0070 with data 1.
- Done bit never set, MAX_POLLS=4 → exactly 4 reads, POLL_GAP idle cycles between them; done_o with error_o=1.
- start_i pulsed while busy, and rst_ni asserted mid-WR_REQ → second start ignored; after reset all valids=0, busy_o=0, FSM accepts a new start.
